uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 87 ++++++++
 tb/tb_uart_tx_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that queues host bytes for a UART transmitter.
// Full/empty come from a registered count; overflow is a sticky flag for pushes attempted while full.
module uart_tx_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       flush,
  input  logic                       clear_ovf,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              push;
  logic              pop;
  logic              ovf_evt;
  logic              af_nxt;

  // Handshake outputs depend only on the registered count.
  assign s_ready = (cnt != CW'(DEPTH));
  assign m_valid = (cnt != '0);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign ovf_evt = s_valid & ~s_ready;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign count   = cnt;

  always_comb begin
    cnt_nxt = cnt;
    if (flush)
      cnt_nxt = '0;
    else if (push && !pop)
      cnt_nxt = cnt + CW'(1);
    else if (pop && !push)
      cnt_nxt = cnt - CW'(1);
    af_nxt = (32'(cnt_nxt) >= 32'(AF_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      almost_full <= af_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      // A new overflow event wins over a concurrent clear.
      if (ovf_evt)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  // Storage is data only; stale entries are never visible because m_data is gated by m_valid.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       flush;
  logic       clear_ovf;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .flush(flush),
    .clear_ovf(clear_ovf), .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       fl;
    logic       co;
    int         ecnt;
    logic       emv;
    logic [7:0] emd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(q.size()));
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("m_data", 32'(m_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("s_ready", 32'(s_ready), 32'(q.size() != DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one clock of inputs, advance the model by the FIFO rules, then check after the edge.
  task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr,
                       input logic fl, input logic co);
    bit full;
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl; clear_ovf = co;
    full = (q.size() == DEPTH);
    if (fl) begin
      q.delete();
    end else begin
      if (mr && q.size() != 0) void'(q.pop_front());
      if (sv && !full) q.push_back(sd);
    end
    if (sv && full) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
    @(posedge clk); #1;
    s_valid = 0; m_ready = 0; flush = 0; clear_ovf = 0;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_almost_full"}, 32'(almost_full), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    rst = 1; s_data = 0; s_valid = 0; m_ready = 0; flush = 0; clear_ovf = 0;
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h11};
    vecs[3] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h22};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h33};
    vecs[7] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].sv, vecs[i].sd, vecs[i].mr, vecs[i].fl, vecs[i].co);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].emv));
      chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].emd));
    end

    // Fill to full, then overflow attempt.
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_almost_full", 32'(almost_full), 1);
    cycle(1, 8'hFF, 0, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(m_data), 32'(i));
      cycle(0, 0, 1, 0, 0);
    end
    chk("drained_m_valid", 32'(m_valid), 0);
    chk("drained_m_data", 32'(m_data), 0);

    // Full again: pop on the same edge does not make room; clear vs new overflow.
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h80 + i), 0, 0, 0);
    cycle(1, 8'hEE, 1, 0, 0);
    chk("full_pushpop_count", 32'(count), 15);
    cycle(1, 8'h90, 0, 0, 0);
    cycle(1, 8'hEF, 0, 0, 1);
    chk("clear_and_ovf", 32'(overflow), 1);
    cycle(0, 0, 0, 0, 1);
    chk("clear_alone", 32'(overflow), 0);

    // Steady push+pop at count 5; pointers wrap.
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h50 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'(8'h60 + i), 1, 0, 0);
      chk($sformatf("steady%0d_count", i), 32'(count), 5);
    end

    // Flush wins over concurrent push and pop.
    cycle(0, 0, 0, 1, 0);
    cycle(1, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(1, 8'(i), 0, 0, 0);
    cycle(1, 8'hAB, 0, 0, 0);
    chk("pre_flush_ovf", 32'(overflow), 1);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h70 + i), 0, 0, 0);
    cycle(1, 8'hC7, 1, 1, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_m_valid", 32'(m_valid), 0);
    chk("flush_ovf_kept", 32'(overflow), 1);
    cycle(1, 8'h12, 0, 0, 0);
    chk("after_flush_head", 32'(m_data), 32'h12);

    // Asynchronous reset between edges at count 9.
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) cycle(1, 8'(8'h90 + i), 0, 0, 0);
    #2 rst = 1;
    #1;
    check_reset_vals("async_rst");
    q.delete(); m_ovf = 1'b0;
    #1 rst = 0;
    @(posedge clk); #1;
    cycle(1, 8'h3C, 0, 0, 0);
    chk("post_rst_head", 32'(m_data), 32'h3C);
    cycle(0, 0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
